romwr_streamer: RTL
===================

ROMWR_STREAMER -- requirements
Module: romwr_streamer

Interface
REQ-001 clk  in  1  system clock, same clock as the SDRAM controller; all logic on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 dl_en  in  1  download active; high for the whole ROM transfer.
REQ-004 dl_wr  in  1  one-cycle byte strobe, honoured only while dl_en=1.
REQ-005 dl_addr  in  24  byte address of dl_data.
REQ-006 dl_data  in  8  download byte.
REQ-007 dl_wait  out  1  backpressure to the downloader; no dl_wr may be issued while high.
REQ-008 romwr_req  out  1  toggle request to the SDRAM ROM-write port.
REQ-009 romwr_ack  in  1  toggle acknowledge; a transfer is complete when romwr_ack==romwr_req.
REQ-010 romwr_a  out  23  word address [23:1], stable from req toggle until ack.
REQ-011 romwr_d  out  16  write data, stable from req toggle until ack.
REQ-012 rom_last_a  out  23  highest word address written this download.
REQ-013 done  out  1  one-cycle pulse when the download has ended and all words are acknowledged.
REQ-014 ovf  out  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-015 Byte assembly: dl_wr with dl_addr[0]=0 SHALL load the hold register (byte plus word address) and set hold_valid.
REQ-016 dl_wr with dl_addr[0]=1 and hold_valid with a matching word address SHALL push {addr, word} and clear hold_valid.
REQ-017 An odd byte with no matching hold SHALL push a word whose even byte is 8'hFF; a mismatched hold is pushed first, padded with 8'hFF, on the same edge.
REQ-018 An even byte arriving while hold_valid SHALL push the old hold padded with odd byte 8'hFF, then load the new hold.
REQ-019 dl_en falling with hold_valid SHALL push the hold padded with 8'hFF.
REQ-020 Byte lanes: the even byte SHALL go to [15:8] and the odd byte to [7:0] (big-endian), unless REQ-036 applies.
REQ-021 FIFO: 4 entries of {23-bit addr, 16-bit data}; 2-bit pointers wrap 3->0; 3-bit count.
REQ-022 A push and a pop on the same edge SHALL leave count unchanged and both SHALL take effect.
REQ-023 A push when count=4 with no pop SHALL be discarded and SHALL set ovf.
REQ-024 dl_wait SHALL be 1 when count>=3 or when the REQ-017 double-push is pending; it is registered.
REQ-025 Handshake FSM states: IDLE and WAIT.
REQ-026 IDLE with count>0: register head into romwr_a/romwr_d, invert romwr_req, pop, go to WAIT (req toggles on the edge after the push edge).
REQ-027 WAIT: remain until romwr_ack==romwr_req, then go to IDLE; the next request issues one cycle later at the earliest.
REQ-028 Each push SHALL update rom_last_a to max(rom_last_a, addr); dl_en rising SHALL clear rom_last_a to 0 and ovf to 0.
REQ-029 An end is pending from dl_en falling; done SHALL pulse on the first cycle with end pending, hold empty, count=0 and state IDLE, and the pending end SHALL then clear.
REQ-030 dl_wr while dl_en=0 SHALL be ignored.
REQ-031 dl_en rising while a request is outstanding SHALL NOT abort it.

Reset
REQ-032 reset SHALL force romwr_req=0, romwr_a=0, romwr_d=0, dl_wait=0, done=0, ovf=0 and rom_last_a=0.
REQ-033 reset SHALL empty the FIFO, clear hold_valid and the pending end, and set the FSM to IDLE.
REQ-034 Reset mid-transfer SHALL abandon the outstanding word; the SDRAM port toggle state is reset together with this block by the system.

Configuration
REQ-035 Macro ROMWR_BYTESWAP_EN controls byte-lane placement.
REQ-036 With ROMWR_BYTESWAP_EN defined, the even byte SHALL go to [7:0] and the odd byte to [15:8]; without it, REQ-020 applies, and padding rules are unchanged in both cases.

Verification
REQ-037 dl_en=1, bytes 12,34 at addresses 0,1, ack returned 3 cycles after req -> one toggle, romwr_a=0, romwr_d=16'h1234, rom_last_a=0.
REQ-038 Eight bytes at consecutive addresses, ack withheld -> dl_wait=1 once count reaches 3, exactly four entries queued, ovf=0.
REQ-039 Byte AB at address 5 (odd, no hold) -> romwr_a=2, romwr_d=16'hFFAB.
REQ-040 Byte CD at address 8, then dl_en falls -> romwr_a=4, romwr_d=16'hCDFF, done pulses one cycle after that ack.
REQ-041 Fifth word pushed with FIFO full, ignoring dl_wait -> ovf=1 and that word is never issued.
REQ-042 reset asserted in WAIT -> romwr_req=0, FIFO empty, done=0, and there is no further toggle until a new push.

Source files
------------

// File: rtl/romwr_streamer.sv
// Byte-to-word download streamer feeding a toggle-handshake SDRAM ROM-write port.
// Optional macro ROMWR_BYTESWAP_EN places the even byte in [7:0] instead of [15:8].
module romwr_streamer (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_en,
    input  logic        dl_wr,
    input  logic [23:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    output logic        romwr_req,
    input  logic        romwr_ack,
    output logic [22:0] romwr_a,
    output logic [15:0] romwr_d,
    output logic [22:0] rom_last_a,
    output logic        done,
    output logic        ovf
);
    localparam int unsigned AW    = 23;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic [DW-1:0] pack_word(input logic [7:0] even, input logic [7:0] odd);
`ifdef ROMWR_BYTESWAP_EN
        return {odd, even};
`else
        return {even, odd};
`endif
    endfunction

    state_t          state, state_nxt;
    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt, free;
    logic            hold_valid, hold_valid_nxt;
    logic [AW-1:0]   hold_addr, hold_addr_nxt;
    logic [7:0]      hold_data, hold_data_nxt;
    logic            dl_en_q, end_pend, end_pend_nxt;
    logic            en_rise, en_fall;
    logic            push0_v, push1_v, acc0, acc1, drop, pop, done_c;
    entry_t          push0, push1, hold_pad, odd_only;
    logic [AW-1:0]   byte_waddr, last_nxt;

    assign en_rise    = dl_en & ~dl_en_q;
    assign en_fall    = ~dl_en & dl_en_q;
    assign byte_waddr = dl_addr[23:1];

    // Byte assembly: up to two words leave the hold stage per edge.
    always_comb begin
        push0_v        = 1'b0;
        push1_v        = 1'b0;
        push0          = '0;
        push1          = '0;
        hold_valid_nxt = hold_valid;
        hold_addr_nxt  = hold_addr;
        hold_data_nxt  = hold_data;
        hold_pad.addr  = hold_addr;
        hold_pad.data  = pack_word(hold_data, 8'hFF);
        odd_only.addr  = byte_waddr;
        odd_only.data  = pack_word(8'hFF, dl_data);
        if (en_fall) begin
            if (hold_valid) begin
                push0_v        = 1'b1;
                push0          = hold_pad;
                hold_valid_nxt = 1'b0;
            end
        end else if (dl_en && dl_wr) begin
            if (!dl_addr[0]) begin
                if (hold_valid) begin
                    push0_v = 1'b1;
                    push0   = hold_pad;
                end
                hold_valid_nxt = 1'b1;
                hold_addr_nxt  = byte_waddr;
                hold_data_nxt  = dl_data;
            end else if (hold_valid && (hold_addr == byte_waddr)) begin
                push0_v        = 1'b1;
                push0.addr     = byte_waddr;
                push0.data     = pack_word(hold_data, dl_data);
                hold_valid_nxt = 1'b0;
            end else begin
                push0_v = 1'b1;
                if (hold_valid) begin
                    push0   = hold_pad;
                    push1_v = 1'b1;
                    push1   = odd_only;
                end else begin
                    push0   = odd_only;
                end
                hold_valid_nxt = 1'b0;
            end
        end
    end

    // Handshake FSM: issue the FIFO head from IDLE, wait for ack to match.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop       = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (romwr_ack == romwr_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO admission, high-water address and end-of-download tracking.
    always_comb begin
        free      = CW'(DEPTH) - count + CW'(pop);
        acc0      = push0_v && (free != '0);
        acc1      = push1_v && ((free - CW'(acc0)) != '0);
        drop      = (push0_v && !acc0) || (push1_v && !acc1);
        count_nxt = count + CW'(acc0) + CW'(acc1) - CW'(pop);
        last_nxt  = en_rise ? '0 : rom_last_a;
        if (acc0 && (push0.addr > last_nxt)) last_nxt = push0.addr;
        if (acc1 && (push1.addr > last_nxt)) last_nxt = push1.addr;
        done_c    = end_pend && !hold_valid && (count == '0) && (state == IDLE);
        end_pend_nxt = end_pend;
        if (en_fall)           end_pend_nxt = 1'b1;
        else if (done_c)       end_pend_nxt = 1'b0;
        else if (en_rise)      end_pend_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (acc0) mem[wr_ptr]          <= push0;
        if (acc1) mem[wr_ptr + PW'(1)] <= push1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
            dl_en_q    <= 1'b0;
            end_pend   <= 1'b0;
            dl_wait    <= 1'b0;
            romwr_req  <= 1'b0;
            romwr_a    <= '0;
            romwr_d    <= '0;
            rom_last_a <= '0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(acc0) + PW'(acc1);
            rd_ptr     <= rd_ptr + PW'(pop);
            count      <= count_nxt;
            hold_valid <= hold_valid_nxt;
            hold_addr  <= hold_addr_nxt;
            hold_data  <= hold_data_nxt;
            dl_en_q    <= dl_en;
            end_pend   <= end_pend_nxt;
            dl_wait    <= (count_nxt >= CW'(3)) || push1_v;
            rom_last_a <= last_nxt;
            done       <= done_c;
            ovf        <= (ovf && !en_rise) || drop;
            if (pop) begin
                romwr_req <= ~romwr_req;
                romwr_a   <= mem[rd_ptr].addr;
                romwr_d   <= mem[rd_ptr].data;
            end
        end
    end
endmodule
